// File: rtl/st_arb_pkg.sv
// Shared types and constants for the serial-transmit arbiter.
// State encoding, default widths and the index-width helper.
package st_arb_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LOAD     = 2'd1,
        SEND     = 2'd2,
        WAIT_ACK = 2'd3
    } arb_state_e;

    localparam int DEF_N_REQ       = 4;
    localparam int DEF_DATA_W      = 8;
    localparam int DEF_TIMEOUT_CYC = 1024;

    // Width of an index into n items; never less than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/st_rr_picker.sv
// Combinational round-robin search: first set request at or above ptr, with wrap.
module st_rr_picker
    import st_arb_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    localparam int IDX_W = idx_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    int               pos_s;
    logic [IDX_W-1:0] cand_s;

    // Scan offsets from the far end down so the nearest hit to ptr is written last.
    always_comb begin
        valid  = 1'b0;
        idx    = {IDX_W{1'b0}};
        pos_s  = 0;
        cand_s = {IDX_W{1'b0}};
        for (int i = N_REQ - 1; i >= 0; i--) begin
            pos_s  = int'(ptr) + i;
            pos_s  = (pos_s >= N_REQ) ? (pos_s - N_REQ) : pos_s;
            cand_s = pos_s[IDX_W-1:0];
            idx    = req[cand_s] ? cand_s : idx;
            valid  = valid | req[cand_s];
        end
    end

endmodule

// File: rtl/st_tx_arbiter.sv
// Round-robin arbiter/sequencer sharing one serial transmitter among N_REQ clients.
// Optional ack timeout enabled by defining ST_ARB_TIMEOUT_EN.
module st_tx_arbiter
    import st_arb_pkg::*;
#(
    parameter int N_REQ       = DEF_N_REQ,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        gnt,
    output logic [N_REQ-1:0]        done,
    input  logic                    tx_ready,
    output logic                    tx_send,
    output logic [DATA_W-1:0]       tx_data,
    input  logic                    tx_ack,
    output logic                    err
);

    localparam int IDX_W = idx_width(N_REQ);

    arb_state_e        state_r;
    logic [IDX_W-1:0]  ptr_r;
    logic [IDX_W-1:0]  idx_r;
    logic [N_REQ-1:0]  gnt_r;
    logic [N_REQ-1:0]  done_r;
    logic              tx_send_r;
    logic [DATA_W-1:0] tx_data_r;
    logic              pick_valid_s;
    logic [IDX_W-1:0]  pick_idx_s;
    logic [IDX_W-1:0]  next_ptr_s;
    logic              timeout_s;

    st_rr_picker #(.N_REQ(N_REQ)) u_picker (
        .req   (req),
        .ptr   (ptr_r),
        .valid (pick_valid_s),
        .idx   (pick_idx_s)
    );

    // Pointer moves just past the index that was served.
    always_comb begin
        next_ptr_s = (idx_r == IDX_W'(N_REQ - 1)) ? IDX_W'(0) : (idx_r + IDX_W'(1));
    end

`ifdef ST_ARB_TIMEOUT_EN
    localparam int CNT_W = idx_width(TIMEOUT_CYC);

    logic [CNT_W-1:0] to_cnt_r;
    logic             err_r;

    // Expires on the TIMEOUT_CYC-th WAIT_ACK cycle without an ack; a late ack still wins.
    always_comb begin
        timeout_s = (state_r == WAIT_ACK) && !tx_ack && (to_cnt_r == CNT_W'(TIMEOUT_CYC - 1));
    end

    // Ack-wait counter, cleared on every entry into WAIT_ACK.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt_r <= {CNT_W{1'b0}};
            err_r    <= 1'b0;
        end else begin
            err_r <= timeout_s;
            if (state_r == SEND) begin
                to_cnt_r <= {CNT_W{1'b0}};
            end else if (state_r == WAIT_ACK) begin
                to_cnt_r <= to_cnt_r + CNT_W'(1);
            end
        end
    end

    assign err = err_r;
`else
    logic [31:0] unused_timeout_s;

    assign unused_timeout_s = 32'(TIMEOUT_CYC);
    assign timeout_s        = 1'b0;
    assign err              = 1'b0;
`endif

    // Arbitration FSM with the data latch and the handshake pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            ptr_r     <= {IDX_W{1'b0}};
            idx_r     <= {IDX_W{1'b0}};
            gnt_r     <= {N_REQ{1'b0}};
            done_r    <= {N_REQ{1'b0}};
            tx_send_r <= 1'b0;
            tx_data_r <= {DATA_W{1'b0}};
        end else begin
            tx_send_r <= 1'b0;
            done_r    <= {N_REQ{1'b0}};
            case (state_r)
                IDLE: begin
                    if (pick_valid_s) begin
                        idx_r     <= pick_idx_s;
                        gnt_r     <= N_REQ'(1) << pick_idx_s;
                        tx_data_r <= req_data[pick_idx_s*DATA_W +: DATA_W];
                        state_r   <= LOAD;
                    end
                end
                LOAD: begin
                    if (tx_ready) begin
                        state_r <= SEND;
                    end
                end
                SEND: begin
                    tx_send_r <= 1'b1;
                    state_r   <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (tx_ack) begin
                        done_r  <= gnt_r;
                        gnt_r   <= {N_REQ{1'b0}};
                        ptr_r   <= next_ptr_s;
                        state_r <= IDLE;
                    end else if (timeout_s) begin
                        gnt_r   <= {N_REQ{1'b0}};
                        ptr_r   <= next_ptr_s;
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign gnt     = gnt_r;
    assign done    = done_r;
    assign tx_send = tx_send_r;
    assign tx_data = tx_data_r;

endmodule

// File: tb/tb_st_tx_arbiter.sv
// Directed self-checking bench for st_tx_arbiter (4 requesters, 8-bit words).
// The timeout section runs only when ST_ARB_TIMEOUT_EN is defined.
module tb_st_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic        tx_ready;
    logic        tx_send;
    logic [7:0]  tx_data;
    logic        tx_ack;
    logic        err;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    st_tx_arbiter #(.N_REQ(4), .DATA_W(8), .TIMEOUT_CYC(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_data (req_data),
        .gnt      (gnt),
        .done     (done),
        .tx_ready (tx_ready),
        .tx_send  (tx_send),
        .tx_data  (tx_data),
        .tx_ack   (tx_ack),
        .err      (err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transfer starting at the grant edge; returns in the done cycle.
    task automatic xfer(input string tag, input logic [3:0] eg, input logic [7:0] ed, input int ack_dly);
        tick();
        chk({tag, ".gnt"}, 32'(gnt), 32'(eg));
        chk({tag, ".data"}, 32'(tx_data), 32'(ed));
        chk({tag, ".done_lo"}, 32'(done), 32'(4'b0000));
        tick();
        chk({tag, ".send_early"}, 32'(tx_send), 32'(1'b0));
        tick();
        chk({tag, ".send"}, 32'(tx_send), 32'(1'b1));
        chk({tag, ".send_data"}, 32'(tx_data), 32'(ed));
        for (int i = 1; i < ack_dly; i++) begin
            tick();
            chk({tag, ".send_once"}, 32'(tx_send), 32'(1'b0));
            chk({tag, ".done_wait"}, 32'(done), 32'(4'b0000));
        end
        tx_ack = 1'b1;
        tick();
        tx_ack = 1'b0;
        chk({tag, ".done"}, 32'(done), 32'(eg));
        chk({tag, ".gnt_clr"}, 32'(gnt), 32'(4'b0000));
        chk({tag, ".err"}, 32'(err), 32'(1'b0));
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        req    = 4'b0000;
        tx_ack = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        req      = 4'b0000;
        req_data = 32'h0000_0000;
        tx_ready = 1'b0;
        tx_ack   = 1'b0;
        tick();
        tick();
        chk("rst.gnt", 32'(gnt), 32'(4'b0000));
        chk("rst.done", 32'(done), 32'(4'b0000));
        chk("rst.send", 32'(tx_send), 32'(1'b0));
        chk("rst.data", 32'(tx_data), 32'(8'h00));
        chk("rst.err", 32'(err), 32'(1'b0));
        rst = 1'b0;

        // Single request, ack four cycles after the send pulse.
        req            = 4'b0001;
        req_data[7:0]  = 8'hA5;
        tx_ready       = 1'b1;
        xfer("single", 4'b0001, 8'hA5, 4);
        req = 4'b0000;
        tick();
        chk("single.done_pulse", 32'(done), 32'(4'b0000));
        chk("single.idle_gnt", 32'(gnt), 32'(4'b0000));

        // All requests held: rotation 0,1,2,3,0 from a fresh pointer.
        do_reset();
        req_data = 32'h4433_2211;
        req      = 4'b1111;
        xfer("rr0", 4'b0001, 8'h11, 1);
        xfer("rr1", 4'b0010, 8'h22, 1);
        xfer("rr2", 4'b0100, 8'h33, 1);
        xfer("rr3", 4'b1000, 8'h44, 1);
        xfer("rr4", 4'b0001, 8'h11, 1);
        req = 4'b0000;
        tick();
        chk("rr.idle_gnt", 32'(gnt), 32'(4'b0000));
        chk("rr.idle_done", 32'(done), 32'(4'b0000));

        // Ready stall: held in LOAD, send exactly two edges after ready rises.
        req_data[15:8] = 8'h5A;
        tx_ready       = 1'b0;
        req            = 4'b0010;
        tick();
        chk("stall.gnt", 32'(gnt), 32'(4'b0010));
        chk("stall.data", 32'(tx_data), 32'(8'h5A));
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("stall.no_send", 32'(tx_send), 32'(1'b0));
            chk("stall.gnt_hold", 32'(gnt), 32'(4'b0010));
        end
        tx_ready = 1'b1;
        tick();
        chk("stall.send_1", 32'(tx_send), 32'(1'b0));
        tick();
        chk("stall.send_2", 32'(tx_send), 32'(1'b1));
        tx_ack = 1'b1;
        tick();
        tx_ack = 1'b0;
        req    = 4'b0000;
        chk("stall.done", 32'(done), 32'(4'b0010));

        // Request and data dropped while waiting for ack.
        req_data[23:16] = 8'hC3;
        req             = 4'b0100;
        tick();
        chk("drop.gnt", 32'(gnt), 32'(4'b0100));
        tick();
        tick();
        chk("drop.send", 32'(tx_send), 32'(1'b1));
        req             = 4'b0000;
        req_data[23:16] = 8'h00;
        tick();
        chk("drop.gnt_hold", 32'(gnt), 32'(4'b0100));
        chk("drop.data_hold", 32'(tx_data), 32'(8'hC3));
        tx_ack = 1'b1;
        tick();
        tx_ack = 1'b0;
        chk("drop.done", 32'(done), 32'(4'b0100));
        tick();
        chk("drop.done_lo", 32'(done), 32'(4'b0000));

        // Stray acks in IDLE and LOAD, then reset in WAIT_ACK.
        tx_ack = 1'b1;
        tick();
        tx_ack = 1'b0;
        chk("stray_idle.gnt", 32'(gnt), 32'(4'b0000));
        chk("stray_idle.done", 32'(done), 32'(4'b0000));
        req_data[31:24] = 8'h77;
        req             = 4'b1000;
        tx_ready        = 1'b0;
        tick();
        chk("stray_load.gnt", 32'(gnt), 32'(4'b1000));
        chk("stray_load.data", 32'(tx_data), 32'(8'h77));
        tx_ack = 1'b1;
        tick();
        tx_ack = 1'b0;
        chk("stray_load.gnt_hold", 32'(gnt), 32'(4'b1000));
        chk("stray_load.done", 32'(done), 32'(4'b0000));
        tx_ready = 1'b1;
        tick();
        chk("stray_load.send_1", 32'(tx_send), 32'(1'b0));
        tick();
        chk("stray_load.send_2", 32'(tx_send), 32'(1'b1));
        tick();
        #2;
        rst = 1'b1;
        #1;
        chk("midrst.gnt", 32'(gnt), 32'(4'b0000));
        chk("midrst.data", 32'(tx_data), 32'(8'h00));
        chk("midrst.send", 32'(tx_send), 32'(1'b0));
        chk("midrst.done", 32'(done), 32'(4'b0000));
        tx_ack = 1'b1;
        tick();
        tx_ack = 1'b0;
        chk("midrst.no_done", 32'(done), 32'(4'b0000));
        rst = 1'b0;
        req = 4'b1001;
        xfer("postrst", 4'b0001, 8'h11, 2);
        req = 4'b0000;

`ifdef ST_ARB_TIMEOUT_EN
        // Withheld ack: err after 16 WAIT_ACK cycles, then the next index wins.
        req = 4'b0110;
        tick();
        chk("to.gnt", 32'(gnt), 32'(4'b0010));
        tick();
        tick();
        chk("to.send", 32'(tx_send), 32'(1'b1));
        for (int i = 1; i < 16; i++) begin
            tick();
            chk("to.err_lo", 32'(err), 32'(1'b0));
            chk("to.gnt_hold", 32'(gnt), 32'(4'b0010));
        end
        tick();
        chk("to.err", 32'(err), 32'(1'b1));
        chk("to.gnt_clr", 32'(gnt), 32'(4'b0000));
        chk("to.no_done", 32'(done), 32'(4'b0000));
        tick();
        chk("to.err_pulse", 32'(err), 32'(1'b0));
        chk("to.next_gnt", 32'(gnt), 32'(4'b0100));
        chk("to.next_done", 32'(done), 32'(4'b0000));
        req = 4'b0000;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
